// File: rtl/adder_pkg.sv
// Shared types and constants for the word adder datapath.
package adder_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } add_flags_t;

endpackage

// File: rtl/word_adder_if.sv
// Operand/result bundle of the word adder.
// The master drives operands; the slave returns the registered sum and flags.
interface word_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output input1, input2,
        input  out, carry_out, overflow, zero
    );

    modport slave (
        input  input1, input2,
        output out, carry_out, overflow, zero
    );
endinterface

// File: rtl/adder_core.sv
// Combinational carry-lookahead adder built from 4-bit CLA groups.
// Groups are chained by their group generate/propagate terms. Operands
// are zero-padded to a multiple of 4 bits; padded bits have p=g=0, so
// the carry out of bit WIDTH-1 is unaffected by the padding.
module adder_core
    import adder_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] ap;
    logic [PW-1:0] bp;
    logic [PW-1:0] p;
    logic [PW-1:0] g;
    logic [PW:0]   c;
    logic [PW-1:0] s;

    assign ap   = PW'(a);
    assign bp   = PW'(b);
    assign p    = ap ^ bp;
    assign g    = ap & bp;
    assign c[0] = cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int B = 4 * gi;
        logic pg;
        logic gg;

        // Group propagate/generate for the whole 4-bit block.
        assign pg = &p[B+3:B];
        assign gg = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        // Intra-group carries all derived directly from the group carry-in.
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = gg | (pg & c[B]);
    end

    assign s    = p ^ c[PW-1:0];
    assign sum  = s[WIDTH-1:0];
    assign cout = c[WIDTH];
    assign cmsb = c[WIDTH-1];

endmodule

// File: rtl/word_adder.sv
// Registered word adder: one-cycle latency sum with carry, signed
// overflow and zero flags. All outputs come straight from flops.
module word_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    word_adder_if.slave  bus
);
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cmsb;
    add_flags_t       flags;

    logic [WIDTH-1:0] out_p0;
    add_flags_t       flags_p0;

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (bus.input1),
        .b    (bus.input2),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb)
    );

    // Status flags for the current sum; signed overflow is carry into the
    // MSB differing from carry out of it.
    always_comb begin
        flags          = '0;
        flags.carry    = cout;
        flags.overflow = cout ^ cmsb;
        flags.zero     = (sum == '0);
    end

    // ---- stage p0: result/flag registers, async reset to the idle sum of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p0         <= '0;
            flags_p0.carry    <= 1'b0;
            flags_p0.overflow <= 1'b0;
            flags_p0.zero     <= 1'b1;
        end else begin
            out_p0   <= sum;
            flags_p0 <= flags;
        end
    end

    assign bus.out       = out_p0;
    assign bus.carry_out = flags_p0.carry;
    assign bus.overflow  = flags_p0.overflow;
    assign bus.zero      = flags_p0.zero;

endmodule

// File: tb/tb_word_adder.sv
// Directed bench for word_adder: reset, wrap, overflow, latency, async reset.
module tb_word_adder;
    import adder_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    word_adder_if #(.WIDTH(DATA_W)) bus ();

    word_adder #(.WIDTH(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands on the falling edge, then sample 1 unit after the rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.input1 = a;
        bus.input2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.input1 = 32'h1234_5678;
        bus.input2 = 32'h0F0F_0F0F;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL rst_out got=%h want=%h", bus.out, 32'h0); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL rst_carry got=%b want=0", bus.carry_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", bus.overflow); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b want=1", bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.out !== 32'h2143_6587) begin bad++; $display("FAIL rst_release got=%h want=%h", bus.out, 32'h2143_6587); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL rst_release_zero got=%b want=0", bus.zero); end
    endtask

    task automatic test_all_ones();
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if (bus.out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ones_out got=%h want=%h", bus.out, 32'hFFFF_FFFE); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL ones_carry got=%b want=1", bus.carry_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ones_ovf got=%b want=0", bus.overflow); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL ones_zero got=%b want=0", bus.zero); end
    endtask

    task automatic test_chain();
        logic [31:0] a_v [5] = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h1};
        logic [31:0] b_v [5] = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'h3, 32'h3};
        logic [31:0] e_v [5] = '{32'hFFFF_FFFF, 32'h1, 32'h3, 32'h5, 32'h4};
        for (int i = 0; i < 5; i++) begin
            apply(a_v[i], b_v[i]);
            total++;
            if (bus.out !== e_v[i]) begin
                bad++;
                $display("FAIL chain_%0d got=%h want=%h", i, bus.out, e_v[i]);
            end
        end
    endtask

    task automatic test_overflow();
        apply(32'h7FFF_FFFF, 32'h0000_0001);
        total++; if (bus.out !== 32'h8000_0000) begin bad++; $display("FAIL ovf_pos_out got=%h want=%h", bus.out, 32'h8000_0000); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pos_ovf got=%b want=1", bus.overflow); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL ovf_pos_carry got=%b want=0", bus.carry_out); end
        apply(32'h8000_0000, 32'h8000_0000);
        total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL ovf_neg_out got=%h want=%h", bus.out, 32'h0); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_neg_ovf got=%b want=1", bus.overflow); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL ovf_neg_carry got=%b want=1", bus.carry_out); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL ovf_neg_zero got=%b want=1", bus.zero); end
    endtask

    task automatic test_back_to_back();
        apply(32'hFFFF_FFFF, 32'h0000_0001);
        total++; if ({bus.out, bus.carry_out, bus.overflow, bus.zero} !== {32'h0, 3'b101})
            begin bad++; $display("FAIL b2b_wrap got=%h/%b%b%b want=00000000/101", bus.out, bus.carry_out, bus.overflow, bus.zero); end
        apply(32'h8000_0000, 32'hFFFF_FFFF);
        total++; if ({bus.out, bus.carry_out, bus.overflow, bus.zero} !== {32'h7FFF_FFFF, 3'b110})
            begin bad++; $display("FAIL b2b_negovf got=%h/%b%b%b want=7fffffff/110", bus.out, bus.carry_out, bus.overflow, bus.zero); end
        apply(32'h1234_5678, 32'h1111_1111);
        total++; if ({bus.out, bus.carry_out, bus.overflow, bus.zero} !== {32'h2345_6789, 3'b000})
            begin bad++; $display("FAIL b2b_plain got=%h/%b%b%b want=23456789/000", bus.out, bus.carry_out, bus.overflow, bus.zero); end
        apply(32'h0000_FFFF, 32'h0000_0001);
        total++; if (bus.out !== 32'h0001_0000) begin bad++; $display("FAIL b2b_grpcarry got=%h want=%h", bus.out, 32'h0001_0000); end
        apply(32'hFFFF_FFFC, 32'h0000_0004);
        total++; if ({bus.out, bus.carry_out, bus.overflow, bus.zero} !== {32'h0, 3'b101})
            begin bad++; $display("FAIL b2b_pc got=%h/%b%b%b want=00000000/101", bus.out, bus.carry_out, bus.overflow, bus.zero); end
    endtask

    task automatic test_latency();
        apply(32'h0000_0010, 32'h0000_0020);
        #2;
        bus.input1 = 32'h0000_0100;
        bus.input2 = 32'h0000_0200;
        @(negedge clk);
        total++; if (bus.out !== 32'h0000_0030) begin bad++; $display("FAIL lat_hold got=%h want=%h", bus.out, 32'h30); end
        @(posedge clk);
        #1;
        total++; if (bus.out !== 32'h0000_0300) begin bad++; $display("FAIL lat_update got=%h want=%h", bus.out, 32'h300); end
    endtask

    task automatic test_async_reset();
        apply(32'h0000_0002, 32'h0000_0003);
        total++; if (bus.out !== 32'h0000_0005) begin bad++; $display("FAIL arst_pre got=%h want=%h", bus.out, 32'h5); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL arst_out got=%h want=%h", bus.out, 32'h0); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL arst_zero got=%b want=1", bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.out !== 32'h0000_0005) begin bad++; $display("FAIL arst_release got=%h want=%h", bus.out, 32'h5); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_ones();
        test_chain();
        test_overflow();
        test_back_to_back();
        test_latency();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
